// File: rtl/alu_result_forward_stage.sv
// alu_result_forward_stage
//
// Consumer side of the ALU result/operand-forward interface. ALU results and flags
// enter the M register (stage 4) and then move to the W register (stage 5). The
// W entry drives the register-file write port and updates the architectural
// {Z,C,S,P} flag register. The carry bit is bypassed back to the ALU. Forwarded
// operands, with their select strobes, are produced from M and W. This block is
// the only source of forwarded operands in the pipeline.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         synchronous reset, active-low
//   alu_result_i   ALU result from stage 3
//   alu_flags_i    ALU flags {Z,C,S,P} from stage 3
//   ex_valid_i     stage-3 instruction valid
//   ex_wr_i        stage-3 instruction writes a register
//   ex_dest_i      destination register index
//   ex_flag_wr_i   stage-3 instruction updates flags
//   stall_i        freeze M and W
//   flush_i        discard the stage-3 instruction
//   id_src_a_i     operand-A source index of the instruction entering the ALU
//   id_src_b_i     operand-B source index
//   rf_we_o        register-file write enable
//   rf_waddr_o     register-file write address
//   rf_wdata_o     register-file write data
//   flags_o        architectural flag register {Z,C,S,P}
//   cin_o          carry to ALU, bypassed from M/W when they carry new flags
//   fwd_a_o        operand A forwarded
//   fwd_b_o        operand B forwarded
//   of_a_o         forwarded operand A (0 when not forwarded)
//   of_b_o         forwarded operand B (0 when not forwarded)

module alu_result_forward_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  input  logic              ex_valid_i,
  input  logic              ex_wr_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic              ex_flag_wr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] id_src_a_i,
  input  logic [REG_AW-1:0] id_src_b_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              cin_o,
  output logic              fwd_a_o,
  output logic              fwd_b_o,
  output logic [DATA_W-1:0] of_a_o,
  output logic [DATA_W-1:0] of_b_o
);

  // Bit position of the carry within the {Z,C,S,P} flag vector.
  localparam int unsigned FlagC = 2;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              flag_wr;
    logic [FLAG_W-1:0] flags;
  } stage_t;

  stage_t            m_q, m_d;
  stage_t            w_q, w_d;
  stage_t            ex_entry;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              flag_commit;

  // Entry presented by the ALU stage this cycle.
  always_comb begin
    ex_entry         = '0;
    ex_entry.valid   = ex_valid_i;
    ex_entry.wr      = ex_wr_i;
    ex_entry.dest    = ex_dest_i;
    ex_entry.data    = alu_result_i;
    ex_entry.flag_wr = ex_flag_wr_i;
    ex_entry.flags   = alu_flags_i;
  end

  // Flags commit on the same edge that retires W. A stalled W keeps its entry,
  // so the commit waits until the stall drops and then happens exactly once.
  assign flag_commit = w_q.valid & w_q.flag_wr & ~stall_i;

  always_comb begin
    m_d     = m_q;
    w_d     = w_q;
    flags_d = flags_q;

    if (flush_i) begin
      // The flush kills the M entry even while stalled. W still obeys the stall.
      m_d.valid = 1'b0;
      if (!stall_i) begin
        w_d = m_q;
      end
    end else if (!stall_i) begin
      w_d = m_q;
      m_d = ex_entry;
    end

    if (flag_commit) begin
      flags_d = w_q.flags;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= '0;
    end else begin
      m_q     <= m_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  // Register-file write port, driven from W.
  assign rf_we_o    = w_q.valid & w_q.wr & ~stall_i;
  assign rf_waddr_o = w_q.dest;
  assign rf_wdata_o = w_q.data;
  assign flags_o    = flags_q;

  // Carry bypass: the youngest in-flight flag update wins over the committed flags.
  always_comb begin
    if (m_q.valid && m_q.flag_wr) begin
      cin_o = m_q.flags[FlagC];
    end else if (w_q.valid && w_q.flag_wr) begin
      cin_o = w_q.flags[FlagC];
    end else begin
      cin_o = flags_q[FlagC];
    end
  end

  // Operand forwarding. R0 has no special treatment. M is younger than W, so M wins.
  logic hit_m_a, hit_w_a, hit_m_b, hit_w_b;

  assign hit_m_a = m_q.valid & m_q.wr & (m_q.dest == id_src_a_i);
  assign hit_w_a = w_q.valid & w_q.wr & (w_q.dest == id_src_a_i);
  assign hit_m_b = m_q.valid & m_q.wr & (m_q.dest == id_src_b_i);
  assign hit_w_b = w_q.valid & w_q.wr & (w_q.dest == id_src_b_i);

  assign fwd_a_o = hit_m_a | hit_w_a;
  assign fwd_b_o = hit_m_b | hit_w_b;

  always_comb begin
    of_a_o = '0;
    if (hit_m_a) begin
      of_a_o = m_q.data;
    end else if (hit_w_a) begin
      of_a_o = w_q.data;
    end
  end

  always_comb begin
    of_b_o = '0;
    if (hit_m_b) begin
      of_b_o = m_q.data;
    end else if (hit_w_b) begin
      of_b_o = w_q.data;
    end
  end

endmodule

// File: tb/tb_alu_result_forward_stage.sv
module tb_alu_result_forward_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] alu_result_i;
  logic [3:0]  alu_flags_i;
  logic        ex_valid_i;
  logic        ex_wr_i;
  logic [2:0]  ex_dest_i;
  logic        ex_flag_wr_i;
  logic        stall_i;
  logic        flush_i;
  logic [2:0]  id_src_a_i;
  logic [2:0]  id_src_b_i;
  logic        rf_we_o;
  logic [2:0]  rf_waddr_o;
  logic [15:0] rf_wdata_o;
  logic [3:0]  flags_o;
  logic        cin_o;
  logic        fwd_a_o;
  logic        fwd_b_o;
  logic [15:0] of_a_o;
  logic [15:0] of_b_o;

  int vectors     = 0;
  int miscompares = 0;

  // Expected register-file writes, {addr, data}, in program order.
  logic [18:0] wr_q[$];

  alu_result_forward_stage dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alu_result_i (alu_result_i),
    .alu_flags_i  (alu_flags_i),
    .ex_valid_i   (ex_valid_i),
    .ex_wr_i      (ex_wr_i),
    .ex_dest_i    (ex_dest_i),
    .ex_flag_wr_i (ex_flag_wr_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .id_src_a_i   (id_src_a_i),
    .id_src_b_i   (id_src_b_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .flags_o      (flags_o),
    .cin_o        (cin_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o),
    .of_a_o       (of_a_o),
    .of_b_o       (of_b_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one ALU-stage instruction; queue its write if it will retire.
  task automatic issue(input logic wr, input logic [2:0] dest, input logic [15:0] data,
                       input logic fwr, input logic [3:0] fl, input logic expect_wr);
    ex_valid_i   = 1'b1;
    ex_wr_i      = wr;
    ex_dest_i    = dest;
    alu_result_i = data;
    ex_flag_wr_i = fwr;
    alu_flags_i  = fl;
    if (expect_wr) wr_q.push_back({dest, data});
  endtask

  task automatic idle();
    ex_valid_i   = 1'b0;
    ex_wr_i      = 1'b0;
    ex_flag_wr_i = 1'b0;
  endtask

  // Scoreboard: every write the DUT performs must be the next queued one.
  always @(negedge clk_i) begin
    if (rf_we_o === 1'b1) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_write: observed R%0d=%0h expected no write", rf_waddr_o,
               rf_wdata_o);
      end else begin
        logic [18:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", {29'd0, rf_waddr_o}, {29'd0, e[18:16]});
        chk("wr_data", {16'd0, rf_wdata_o}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    // 1: reset held with a valid writing instruction present.
    rst_ni = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    id_src_a_i = 3'd7;
    id_src_b_i = 3'd7;
    issue(1'b1, 3'd7, 16'hFFFF, 1'b1, 4'hF, 1'b0);
    tick(); tick(); tick();
    rst_ni = 1'b1;
    idle();
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_flags", flags_o, 0);
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_fwd_b", fwd_b_o, 0);
    chk("rst_cin", cin_o, 0);
    chk("rst_of_a", of_a_o, 0);
    tick();
    chk("post_rst_rf_we", rf_we_o, 0);
    chk("post_rst_fwd_a", fwd_a_o, 0);

    // 2: back-to-back writes to R3, M beats W.
    issue(1'b1, 3'd3, 16'h1234, 1'b0, 4'h0, 1'b1);
    id_src_a_i = 3'd0;
    tick();
    issue(1'b1, 3'd3, 16'hBEEF, 1'b0, 4'h0, 1'b1);
    id_src_a_i = 3'd3;
    #1;
    chk("b2b_fwd_m_only", fwd_a_o, 1);
    chk("b2b_of_m_only", of_a_o, 16'h1234);
    chk("b2b_no_write_yet", rf_we_o, 0);
    tick();
    idle();
    #1;
    chk("b2b_fwd_a", fwd_a_o, 1);
    chk("b2b_of_a_m_over_w", of_a_o, 16'hBEEF);
    chk("b2b_rf_we", rf_we_o, 1);
    chk("b2b_waddr", rf_waddr_o, 3);
    chk("b2b_wdata", rf_wdata_o, 16'h1234);
    tick();
    chk("b2b_of_a_from_w", of_a_o, 16'hBEEF);
    tick();
    chk("b2b_drained_fwd", fwd_a_o, 0);
    chk("b2b_drained_of", of_a_o, 0);

    // 3: stall holds M; one write after release.
    issue(1'b1, 3'd2, 16'h00FF, 1'b0, 4'h0, 1'b1);
    id_src_b_i = 3'd2;
    tick();
    idle();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rf_we", rf_we_o, 0);
      chk("stall_of_b", of_b_o, 16'h00FF);
    end
    stall_i = 1'b0;
    tick();
    chk("stall_release_we", rf_we_o, 1);
    chk("stall_release_wdata", rf_wdata_o, 16'h00FF);
    tick();
    chk("stall_once", rf_we_o, 0);

    // 4: flushed instruction never forwards or writes.
    issue(1'b1, 3'd5, 16'h5555, 1'b0, 4'h0, 1'b0);
    flush_i = 1'b1;
    id_src_a_i = 3'd5;
    tick();
    flush_i = 1'b0;
    idle();
    chk("flush_fwd_m", fwd_a_o, 0);
    tick();
    chk("flush_fwd_w", fwd_a_o, 0);
    chk("flush_no_write", rf_we_o, 0);
    tick();

    // 5: flags and carry bypass.
    issue(1'b1, 3'd4, 16'h0010, 1'b1, 4'b0100, 1'b1);
    tick();
    idle();
    chk("cin_from_m", cin_o, 1);
    chk("flags_not_yet", flags_o, 0);
    tick();
    chk("cin_from_w", cin_o, 1);
    chk("flags_not_yet_w", flags_o, 0);
    tick();
    chk("flags_commit", flags_o, 4'b0100);
    chk("cin_from_reg", cin_o, 1);
    issue(1'b0, 3'd0, 16'h0000, 1'b1, 4'b1000, 1'b0);
    tick();
    idle();
    chk("cin_m_overrides_reg", cin_o, 0);
    tick();
    chk("cin_w_overrides_reg", cin_o, 0);
    tick();
    chk("flags_commit2", flags_o, 4'b1000);
    chk("cin_reg2", cin_o, 0);

    // 6: R0 in M, R1 in W, both operands forwarded.
    issue(1'b1, 3'd1, 16'h0002, 1'b0, 4'h0, 1'b1);
    tick();
    issue(1'b1, 3'd0, 16'h0001, 1'b0, 4'h0, 1'b1);
    tick();
    idle();
    id_src_a_i = 3'd0;
    id_src_b_i = 3'd1;
    #1;
    chk("r0_fwd_a", fwd_a_o, 1);
    chk("r0_fwd_b", fwd_b_o, 1);
    chk("r0_of_a", of_a_o, 16'h0001);
    chk("r0_of_b", of_b_o, 16'h0002);
    id_src_b_i = 3'd6;
    #1;
    chk("miss_fwd_b", fwd_b_o, 0);
    chk("miss_of_b", of_b_o, 0);
    tick();
    tick();

    // Reset while stalled drops the in-flight result.
    issue(1'b1, 3'd6, 16'h6666, 1'b1, 4'b0100, 1'b0);
    tick();
    idle();
    stall_i = 1'b1;
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    stall_i = 1'b0;
    id_src_a_i = 3'd6;
    #1;
    chk("rst_stall_fwd", fwd_a_o, 0);
    chk("rst_stall_flags", flags_o, 0);
    chk("rst_stall_cin", cin_o, 0);
    tick();
    tick();

    chk("pending_writes", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
